// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants and helpers for the register-file read-port arbiter and
// its sibling arbiters.
package regfile_read_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // The response register is the only state; resp_valid encodes it directly.
    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_VALID = 1'b1
    } resp_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_priority_picker.sv
// Round-robin picker: scans from last+1 upward (mod N) and returns the first
// set request as both a one-hot grant and an encoded index.
module rr_priority_picker
    import regfile_read_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        // k = N wraps back to last itself, so it has the lowest priority.
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port; returns the read
// word with the requester's ID one cycle after acceptance.
module regfile_read_arbiter
    import regfile_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [REG_ADDR_W-1:0]         rd_select,
    input  logic [DATA_W-1:0]             rd_data,
    input  logic                          resp_stall,
    output logic                          resp_valid,
    output logic [ID_W-1:0]               resp_id,
    output logic [DATA_W-1:0]             resp_data
);

    logic [NUM_REQ-1:0][REG_ADDR_W-1:0] addr_arr;
    logic [NUM_REQ-1:0]                 req_masked;
    logic [NUM_REQ-1:0]                 gnt;
    logic [ID_W-1:0]                    gnt_idx;
    logic                               gnt_any;
    logic [ID_W-1:0]                    last;

    assign addr_arr = req_addr;

    // A stalled downstream freezes everything, so no request is even offered.
    assign req_masked = resp_stall ? '0 : req_valid;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_picker (
        .req  (req_masked),
        .last (last),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    assign req_ready = gnt;
    assign rd_select = gnt_any ? addr_arr[gnt_idx] : ZERO_REG;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            last       <= ID_W'(NUM_REQ - 1);
        end else if (!resp_stall) begin
            resp_valid <= gnt_any;
            if (gnt_any) begin
                resp_id   <= gnt_idx;
                last      <= gnt_idx;
                // r0 reads as zero regardless of what the mux presents.
                resp_data <= (rd_select == ZERO_REG) ? '0 : rd_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a response scoreboard queue.
module tb_regfile_read_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [19:0] req_addr;
    logic [3:0]  req_ready;
    logic [4:0]  rd_select;
    logic [31:0] rd_data;
    logic        resp_stall;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [31:0] resp_data;
    logic        force_ones;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    exp_t held;
    logic held_valid;
    int   errors;
    int   checks;

    regfile_read_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rd_select  (rd_select),
        .rd_data    (rd_data),
        .resp_stall (resp_stall),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register mux model: a recognisable word per address, or all ones on demand.
    assign rd_data = force_ones ? 32'hFFFF_FFFF : {16'hDEAD, 11'h0, rd_select};

    function automatic logic [31:0] model_word(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (force_ones) return 32'hFFFF_FFFF;
        return {16'hDEAD, 11'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input logic [4:0] a0, input logic [4:0] a1,
                            input logic [4:0] a2, input logic [4:0] a3);
        req_addr = {a3, a2, a1, a0};
    endtask

    // One cycle: inputs already driven at the negedge. exp_g < 0 means no grant.
    task automatic cyc(input int exp_g, input logic [4:0] exp_sel);
        exp_t e;
        #1;
        chk("req_ready", 32'(req_ready), (exp_g < 0) ? 32'h0 : 32'(1 << exp_g));
        chk("rd_select", 32'(rd_select), 32'(exp_sel));
        if (exp_g >= 0) begin
            e.id   = 2'(exp_g);
            e.data = model_word(exp_sel);
            q.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
        if (exp_g >= 0) begin
            held       = q.pop_front();
            held_valid = 1'b1;
            chk("resp_valid", 32'(resp_valid), 32'h1);
            chk("resp_id",    32'(resp_id),    32'(held.id));
            chk("resp_data",  resp_data,       held.data);
        end else if (resp_stall) begin
            chk("stall_valid", 32'(resp_valid), 32'(held_valid));
            if (held_valid) begin
                chk("stall_id",   32'(resp_id), 32'(held.id));
                chk("stall_data", resp_data,    held.data);
            end
        end else begin
            held_valid = 1'b0;
            chk("idle_valid", 32'(resp_valid), 32'h0);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        held_valid = 1'b0;
        held.id    = '0;
        held.data  = '0;
        force_ones = 1'b0;
        resp_stall = 1'b0;
        reset      = 1'b0;
        req_valid  = 4'b1111;
        set_addr(5'd1, 5'd2, 5'd3, 5'd4);

        // Held in reset with every requester asking.
        repeat (2) @(negedge clock);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_data",  resp_data,       32'h0);
        chk("rst_id",    32'(resp_id),    32'h0);
        reset = 1'b1;

        // All requesters: rotation 0,1,2,3 repeated, starting at 0.
        cyc(0, 5'd1);
        for (int r = 0; r < 2; r++) begin
            cyc(1, 5'd2);
            cyc(2, 5'd3);
            cyc(3, 5'd4);
            if (r == 0) cyc(0, 5'd1);
        end

        // Single requester 0 reading r7.
        req_valid = 4'b0001;
        set_addr(5'd7, 5'd2, 5'd3, 5'd4);
        cyc(0, 5'd7);

        req_valid = 4'b0000;
        cyc(-1, 5'd0);

        // r0 reads zero even when the mux drives all ones.
        force_ones = 1'b1;
        req_valid  = 4'b0100;
        set_addr(5'd7, 5'd2, 5'd0, 5'd4);
        cyc(2, 5'd0);
        force_ones = 1'b0;

        // Accept req1, then stall with req0/req2 pending.
        req_valid = 4'b0010;
        set_addr(5'd5, 5'd3, 5'd6, 5'd4);
        cyc(1, 5'd3);
        req_valid  = 4'b0101;
        resp_stall = 1'b1;
        repeat (3) cyc(-1, 5'd0);
        resp_stall = 1'b0;
        cyc(2, 5'd6);
        cyc(0, 5'd5);

        // Asynchronous reset while a response is valid.
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(resp_valid), 32'h0);
        chk("async_data",  resp_data,       32'h0);
        held_valid = 1'b0;
        @(negedge clock);
        req_valid = 4'b1111;
        set_addr(5'd9, 5'd10, 5'd11, 5'd12);
        reset = 1'b1;
        cyc(0, 5'd9);
        cyc(1, 5'd10);

        req_valid = 4'b0000;
        cyc(-1, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
